// File: rtl/pipe_result_monitor_pkg.sv
// Shared definitions for the pipeline result monitor: default width,
// FSM state encoding and the golden expected-result function.
package pipe_result_monitor_pkg;

   localparam int N_DEF = 10;
   localparam int WMAX  = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      TRACK = 2'd1,
      HALT  = 2'd2
   } state_t;

   // F = ((A+B)+(C-D))*D, evaluated wide; callers truncate to N bits.
   // The low N bits of wrap-around arithmetic equal the exact result
   // mod 2^N, so a fixed wide width serves every N <= WMAX.
   function automatic logic [WMAX-1:0] exp_f(
      input logic [WMAX-1:0] a,
      input logic [WMAX-1:0] b,
      input logic [WMAX-1:0] c,
      input logic [WMAX-1:0] d
   );
      return ((a + b) + (c - d)) * d;
   endfunction

endpackage

// File: rtl/pipe_result_monitor_if.sv
// Pipeline tap bundle: operand entry strobe + operands, result strobe + F.
// master drives (pipeline side), slave observes (monitor side).
interface pipe_result_monitor_if
   import pipe_result_monitor_pkg::*;
#(
   parameter int N = N_DEF
);

   logic         in_valid;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic [N-1:0] c;
   logic [N-1:0] d;
   logic         out_valid;
   logic [N-1:0] f;

   modport master (
      output in_valid, a, b, c, d,
      output out_valid, f
   );

   modport slave (
      input in_valid, a, b, c, d,
      input out_valid, f
   );

endinterface

// File: rtl/pipe_result_monitor_sync_fifo.sv
// Show-ahead synchronous FIFO holding expected results.
// Ports: clk, rst (sync, high), push/din, pop/dout, full, empty, cnt.
module sync_fifo
   import pipe_result_monitor_pkg::*;
#(
   parameter int WIDTH = N_DEF,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   cnt
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wp;
   logic [AW:0]      rp;

   // Extra MSB tells a full ring from an empty one.
   assign empty = (wp == rp);
   assign full  = (wp[AW] != rp[AW]) &&
                  (wp[AW-1:0] == rp[AW-1:0]);
   assign cnt   = wp - rp;
   assign dout  = mem[rp[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         wp <= '0;
         rp <= '0;
      end else begin
         if (push) wp <= wp + 1'b1;
         if (pop)  rp <= rp + 1'b1;
      end
   end

   // Storage is not reset; pointers define validity.
   always_ff @(posedge clk) begin
      if (push) mem[wp[AW-1:0]] <= din;
   end

endmodule

// File: rtl/pipe_result_monitor.sv
// In-order response checker for the 4-operand arithmetic pipeline.
// Ports: clk, rst (sync, high); bus (slave: in_valid,a..d,out_valid,f);
// match_cnt, mism_cnt (16b saturating); err_flag, ovf, udf, tmo (sticky);
// first_exp, first_got (first mismatch/timeout detail); busy (queue non-empty).
module pipe_result_monitor
   import pipe_result_monitor_pkg::*;
#(
   parameter int N        = N_DEF,
   parameter int DEPTH    = 8,
   parameter int TMO      = 16,
   parameter bit HALT_ERR = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst,
   pipe_result_monitor_if.slave bus,
   output logic [15:0]          match_cnt,
   output logic [15:0]          mism_cnt,
   output logic                 err_flag,
   output logic [N-1:0]         first_exp,
   output logic [N-1:0]         first_got,
   output logic                 ovf,
   output logic                 udf,
   output logic                 tmo,
   output logic                 busy
);

   localparam int AW  = $clog2(DEPTH);
   localparam int AGW = $clog2(TMO + 1);

   state_t         state_q;
   state_t         state_d;
   logic           halted;
   logic           full;
   logic           empty;
   logic [AW:0]    cnt;
   logic [N-1:0]   head;
   logic [N-1:0]   exp_v;
   logic [AGW-1:0] age_q;
   logic           push;
   logic           pop;
   logic           chk;
   logic           hit;
   logic           miss;
   logic           tout;
   logic           ovf_ev;
   logic           udf_ev;
   logic           err_ev;
   logic           first_seen;

   assign halted = (state_q == HALT);
   assign busy   = !empty;

   assign exp_v = N'(exp_f(WMAX'(bus.a), WMAX'(bus.b),
                           WMAX'(bus.c), WMAX'(bus.d)));

   // A real result always wins over a timeout in the same cycle.
   // The timeout fires on the TMO-th cycle the head has waited.
   assign chk  = !halted && bus.out_valid && !empty;
   assign tout = !halted && !bus.out_valid && !empty &&
                 (age_q == AGW'(TMO - 1));
   assign pop  = chk || tout;

   // A pop in the same cycle frees the slot, even when full.
   assign push   = !halted && bus.in_valid && (!full || pop);
   assign ovf_ev = !halted && bus.in_valid && full && !pop;
   assign udf_ev = !halted && bus.out_valid && empty;

   assign hit    = chk && (head == bus.f);
   assign miss   = chk && (head != bus.f);
   assign err_ev = miss || tout || ovf_ev || udf_ev;

   sync_fifo #(
      .WIDTH (N),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .din   (exp_v),
      .pop   (pop),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .cnt   (cnt)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (push) state_d = TRACK;
         end
         TRACK: begin
            if (pop && !push && (cnt == (AW+1)'(1)))
               state_d = IDLE;
         end
         HALT:    state_d = HALT;
         default: state_d = IDLE;
      endcase
      if (HALT_ERR && err_ev) state_d = HALT;
   end

   // Age of the current head entry; frozen while halted.
   always_ff @(posedge clk) begin
      if (rst) begin
         age_q <= '0;
      end else if (!halted) begin
         if (pop || (push && empty))
            age_q <= '0;
         else if (!empty)
            age_q <= age_q + AGW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         match_cnt  <= '0;
         mism_cnt   <= '0;
         err_flag   <= 1'b0;
         ovf        <= 1'b0;
         udf        <= 1'b0;
         tmo        <= 1'b0;
         first_exp  <= '0;
         first_got  <= '0;
         first_seen <= 1'b0;
      end else begin
         if (hit && (match_cnt != 16'hFFFF))
            match_cnt <= match_cnt + 16'd1;
         if ((miss || tout) && (mism_cnt != 16'hFFFF))
            mism_cnt <= mism_cnt + 16'd1;
         if (err_ev) err_flag <= 1'b1;
         if (ovf_ev) ovf      <= 1'b1;
         if (udf_ev) udf      <= 1'b1;
         if (tout)   tmo      <= 1'b1;
         // Detail registers capture only the first compare failure.
         if ((miss || tout) && !first_seen) begin
            first_seen <= 1'b1;
            first_exp  <= head;
            first_got  <= tout ? '0 : bus.f;
         end
      end
   end

endmodule

// File: tb/tb_pipe_result_monitor.sv
// Bench for pipe_result_monitor: directed table, corner sequences,
// and random traffic against a queue-based reference model.
module tb_pipe_result_monitor;

   localparam int N     = 10;
   localparam int DEPTH = 8;
   localparam int TMO   = 16;
   localparam int MASK  = (1 << N) - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pipe_result_monitor_if #(.N(N)) bus ();

   logic [15:0]  match0, mism0, match1, mism1;
   logic         err0, ovf0, udf0, tmo0, busy0;
   logic         err1, ovf1, udf1, tmo1, busy1;
   logic [N-1:0] fexp0, fgot0, fexp1, fgot1;

   pipe_result_monitor #(
      .N(N), .DEPTH(DEPTH), .TMO(TMO), .HALT_ERR(1'b0)
   ) u0 (
      .clk(clk), .rst(rst), .bus(bus),
      .match_cnt(match0), .mism_cnt(mism0), .err_flag(err0),
      .first_exp(fexp0), .first_got(fgot0),
      .ovf(ovf0), .udf(udf0), .tmo(tmo0), .busy(busy0)
   );

   pipe_result_monitor #(
      .N(N), .DEPTH(DEPTH), .TMO(TMO), .HALT_ERR(1'b1)
   ) u1 (
      .clk(clk), .rst(rst), .bus(bus),
      .match_cnt(match1), .mism_cnt(mism1), .err_flag(err1),
      .first_exp(fexp1), .first_got(fgot1),
      .ovf(ovf1), .udf(udf1), .tmo(tmo1), .busy(busy1)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got=%0d expected=%0d @%0t", nm, got, exp, $time);
      end
   endtask

   function automatic int exp_ref(input int a, b, c, d);
      return (((a + b) + (c - d)) * d) & MASK;
   endfunction

   // Reference model: queue of expected results plus sticky state.
   int q[$];
   int t, head_t;
   int m_match, m_mism, m_fexp, m_fgot;
   bit m_err, m_ovf, m_udf, m_tmo, m_first;

   task automatic note_err(input int h, input int g);
      if (m_mism < 65535) m_mism++;
      m_err = 1;
      if (!m_first) begin
         m_first = 1; m_fexp = h; m_fgot = g;
      end
   endtask

   task automatic model_step(input int r, iv, a, b, c, d, ov, f);
      int h;
      bit popped;
      t++;
      if (r != 0) begin
         q.delete();
         m_match = 0; m_mism = 0; m_fexp = 0; m_fgot = 0;
         m_err = 0; m_ovf = 0; m_udf = 0; m_tmo = 0; m_first = 0;
         head_t = t;
         return;
      end
      popped = 0;
      if (ov != 0) begin
         if (q.size() == 0) begin
            m_udf = 1; m_err = 1;
         end else begin
            h = q.pop_front();
            popped = 1;
            if (h == f) begin
               if (m_match < 65535) m_match++;
            end else note_err(h, f);
         end
      end else if (q.size() > 0 && (t - head_t) == TMO) begin
         h = q.pop_front();
         popped = 1;
         m_tmo = 1;
         note_err(h, 0);
      end
      if (popped) head_t = t;
      if (iv != 0) begin
         if (q.size() < DEPTH) begin
            if (q.size() == 0) head_t = t;
            q.push_back(exp_ref(a, b, c, d));
         end else begin
            m_ovf = 1; m_err = 1;
         end
      end
   endtask

   // Apply one cycle of stimulus; returns at the next falling edge.
   task automatic cyc(input int r, iv, a, b, c, d, ov, f);
      rst           = (r != 0);
      bus.in_valid  = (iv != 0);
      bus.a         = N'(a);
      bus.b         = N'(b);
      bus.c         = N'(c);
      bus.d         = N'(d);
      bus.out_valid = (ov != 0);
      bus.f         = N'(f);
      model_step(r, iv, a, b, c, d, ov, f);
      @(negedge clk);
   endtask

   task automatic idle();
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic check_model();
      chk("rnd_match", int'(match0), m_match);
      chk("rnd_mism",  int'(mism0),  m_mism);
      chk("rnd_err",   int'(err0),   int'(m_err));
      chk("rnd_ovf",   int'(ovf0),   int'(m_ovf));
      chk("rnd_udf",   int'(udf0),   int'(m_udf));
      chk("rnd_tmo",   int'(tmo0),   int'(m_tmo));
      chk("rnd_busy",  int'(busy0),  int'(q.size() != 0));
      chk("rnd_fexp",  int'(fexp0),  m_fexp);
      chk("rnd_fgot",  int'(fgot0),  m_fgot);
   endtask

   typedef struct {
      int r, iv, a, b, c, d, ov, f;
      int match, mism, err, ovf, udf, tmo, busy, fexp, fgot;
   } vec_t;

   vec_t tbl[14];
   int   ex[10];
   int   ia, ib, ic, id, iv, ov, fv;

   initial begin
      tbl[0]  = '{1,0,0,0,0,0,0,0,     0,0,0,0,0,0,0,0,0};
      tbl[1]  = '{0,0,0,0,0,0,1,0,     0,0,1,0,1,0,0,0,0};
      tbl[2]  = '{1,0,0,0,0,0,0,0,     0,0,0,0,0,0,0,0,0};
      tbl[3]  = '{0,1,10,12,6,3,0,0,   0,0,0,0,0,0,1,0,0};
      tbl[4]  = '{0,0,0,0,0,0,0,0,     0,0,0,0,0,0,1,0,0};
      tbl[5]  = '{0,0,0,0,0,0,0,0,     0,0,0,0,0,0,1,0,0};
      tbl[6]  = '{0,0,0,0,0,0,0,0,     0,0,0,0,0,0,1,0,0};
      tbl[7]  = '{0,0,0,0,0,0,1,75,    1,0,0,0,0,0,0,0,0};
      tbl[8]  = '{0,1,20,30,40,50,0,0, 1,0,0,0,0,0,1,0,0};
      tbl[9]  = '{0,0,0,0,0,0,1,976,   2,0,0,0,0,0,0,0,0};
      tbl[10] = '{0,1,20,30,40,50,0,0, 2,0,0,0,0,0,1,0,0};
      tbl[11] = '{0,0,0,0,0,0,1,977,   2,1,1,0,0,0,0,976,977};
      tbl[12] = '{0,1,10,12,6,3,1,5,   2,1,1,0,1,0,1,976,977};
      tbl[13] = '{0,0,0,0,0,0,1,75,    3,1,1,0,1,0,0,976,977};

      bus.in_valid = 1'b0; bus.out_valid = 1'b0;
      bus.a = '0; bus.b = '0; bus.c = '0; bus.d = '0; bus.f = '0;
      @(negedge clk);

      // Directed table: reset, underflow, match, mismatch, udf+push.
      for (int i = 0; i < 14; i++) begin
         cyc(tbl[i].r, tbl[i].iv, tbl[i].a, tbl[i].b,
             tbl[i].c, tbl[i].d, tbl[i].ov, tbl[i].f);
         chk("tbl_match", int'(match0), tbl[i].match);
         chk("tbl_mism",  int'(mism0),  tbl[i].mism);
         chk("tbl_err",   int'(err0),   tbl[i].err);
         chk("tbl_ovf",   int'(ovf0),   tbl[i].ovf);
         chk("tbl_udf",   int'(udf0),   tbl[i].udf);
         chk("tbl_tmo",   int'(tmo0),   tbl[i].tmo);
         chk("tbl_busy",  int'(busy0),  tbl[i].busy);
         chk("tbl_fexp",  int'(fexp0),  tbl[i].fexp);
         chk("tbl_fgot",  int'(fgot0),  tbl[i].fgot);
      end

      // Overflow: 9 pushes into an 8-deep queue, then push+pop while full.
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 10; i++) ex[i] = exp_ref(i + 1, 2 * i + 3, 3 * i, i + 2);
      for (int i = 0; i < 9; i++) cyc(0, 1, i + 1, 2 * i + 3, 3 * i, i + 2, 0, 0);
      chk("ovf_flag", int'(ovf0), 1);
      chk("ovf_err",  int'(err0), 1);
      chk("ovf_busy", int'(busy0), 1);
      chk("ovf_mism", int'(mism0), 0);
      cyc(0, 1, 10, 21, 27, 11, 1, ex[0]);
      chk("full_pp_match", int'(match0), 1);
      for (int i = 1; i < 8; i++) cyc(0, 0, 0, 0, 0, 0, 1, ex[i]);
      chk("drain7_busy", int'(busy0), 1);
      cyc(0, 0, 0, 0, 0, 0, 1, ex[9]);
      chk("drain8_busy",  int'(busy0),  0);
      chk("drain8_match", int'(match0), 9);
      chk("drain8_mism",  int'(mism0),  0);
      chk("drain8_udf",   int'(udf0),   0);

      // Timeout: head withheld for TMO cycles.
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 1, 20, 30, 40, 50, 0, 0);
      for (int i = 0; i < TMO - 1; i++) idle();
      chk("tmo_early", int'(tmo0),  0);
      chk("tmo_ebusy", int'(busy0), 1);
      idle();
      chk("tmo_flag", int'(tmo0),  1);
      chk("tmo_mism", int'(mism0), 1);
      chk("tmo_fexp", int'(fexp0), 976);
      chk("tmo_fgot", int'(fgot0), 0);
      chk("tmo_busy", int'(busy0), 0);
      chk("tmo_err",  int'(err0),  1);

      // Halt-on-error instance: freeze after mismatch, recover by reset.
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 1, 10, 12, 6, 3, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 1, 74);
      chk("halt_mism", int'(mism1), 1);
      chk("halt_fexp", int'(fexp1), 75);
      chk("halt_fgot", int'(fgot1), 74);
      for (int i = 0; i < 3; i++) begin
         cyc(0, 1, 10, 12, 6, 3, 0, 0);
         cyc(0, 0, 0, 0, 0, 0, 1, 75);
      end
      chk("halt_match", int'(match1), 0);
      chk("halt_mism2", int'(mism1),  1);
      chk("halt_busy",  int'(busy1),  0);
      chk("halt_udf",   int'(udf1),   0);
      chk("nohalt_match", int'(match0), 3);
      cyc(0, 1, 10, 12, 6, 3, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      chk("hrst_match", int'(match1), 0);
      chk("hrst_mism",  int'(mism1),  0);
      chk("hrst_err",   int'(err1),   0);
      chk("hrst_fexp",  int'(fexp1),  0);
      chk("hrst_fgot",  int'(fgot1),  0);
      chk("hrst_busy",  int'(busy0) + int'(busy1), 0);
      cyc(0, 1, 10, 12, 6, 3, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 1, 75);
      chk("hrst_rematch", int'(match1), 1);
      chk("hrst_reerr",   int'(err1),   0);

      // Random traffic with stalls that provoke timeouts and overflow.
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 900; i++) begin
         ia = int'($urandom_range(0, MASK));
         ib = int'($urandom_range(0, MASK));
         ic = int'($urandom_range(0, MASK));
         id = int'($urandom_range(0, MASK));
         if ((i % 200) >= 150) begin
            iv = int'($urandom_range(0, 9) < 7);
            ov = 0;
         end else begin
            iv = int'($urandom_range(0, 1));
            ov = int'($urandom_range(0, 99) < 45);
         end
         if (q.size() > 0 && $urandom_range(0, 9) != 0) fv = q[0];
         else fv = int'($urandom_range(0, MASK));
         cyc((i == 450) ? 1 : 0, iv, ia, ib, ic, id, ov, fv);
         check_model();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
